// File: rtl/lib_arbiter_pkg.sv
// Shared parameters and types for the row/column arbiter readout path.
package lib_arbiter_pkg;
  localparam int ROWS   = 8;
  localparam int ADDR_W = $clog2(ROWS);

  typedef enum logic {IDLE, SEND} arb_req_state_t;
endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary encoder; returns the index of the lowest set bit.
// Purely combinational, shared by row and column readout.
module onehot_to_bin #(
  parameter int W     = 8,
  parameter int OUT_W = $clog2(W)
) (
  input  logic [W-1:0]     i_onehot,
  output logic [OUT_W-1:0] o_bin
);
  // Scan from the top down so the lowest set bit overrides any higher one.
  always_comb begin
    o_bin = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_onehot[i]) o_bin = OUT_W'(i);
    end
  end
endmodule

// File: rtl/arb_req_handler.sv
// Requester-side companion of the priority arbiter: latches event pulses into
// pending flags, presents them as requests, captures the returned one-hot
// grant, and emits its binary address under valid/ready.
// Optional macro GNT_ONEHOT_CHK_EN builds a sticky grant-protocol checker.
module arb_req_handler
  import lib_arbiter_pkg::*;
#(
  parameter int ROWS   = lib_arbiter_pkg::ROWS,
  parameter int ADDR_W = $clog2(ROWS)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ROWS-1:0]   evt_i,
  output logic [ROWS-1:0]   req_o,
  input  logic [ROWS-1:0]   gnt_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              err_o
);
  arb_req_state_t    r_state, w_state_d;
  logic [ROWS-1:0]   r_pending;
  logic [ADDR_W-1:0] r_addr;
  logic              w_cap_en;
  logic              w_gnt_any;
  logic              w_capture;
  logic [ROWS-1:0]   w_clr;
  logic [ADDR_W-1:0] w_enc;

  onehot_to_bin #(.W(ROWS), .OUT_W(ADDR_W)) u_enc (
    .i_onehot (gnt_i),
    .o_bin    (w_enc)
  );

  assign w_gnt_any = |gnt_i;

  // Capture window: idle, or the current address is being handed off.
  always_comb begin
    w_cap_en  = (r_state == IDLE) || ((r_state == SEND) && ready_i);
    w_capture = w_cap_en && w_gnt_any;
    w_clr     = w_capture ? gnt_i : '0;
    w_state_d = r_state;
    case (r_state)
      IDLE: if (w_gnt_any) w_state_d = SEND;
      SEND: if (ready_i)   w_state_d = w_gnt_any ? SEND : IDLE;
      default:             w_state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_state_d;
  end

  // Pending flags: set wins over the capture clear, so a same-cycle event re-pends.
  always_ff @(posedge clk_i) begin
    if (reset_i) r_pending <= '0;
    else         r_pending <= (r_pending & ~w_clr) | evt_i;
  end

  // Address register only loads on capture, so it holds while stalled.
  always_ff @(posedge clk_i) begin
    if (reset_i)        r_addr <= '0;
    else if (w_capture) r_addr <= w_enc;
  end

  assign req_o   = r_pending;
  assign addr_o  = r_addr;
  assign valid_o = (r_state == SEND);
  assign busy_o  = (|r_pending) || valid_o;

`ifdef GNT_ONEHOT_CHK_EN
  logic r_err;
  logic w_onehot;
  logic w_gnt_bad;

  // Grant must be exactly one bit and must target a pending line.
  always_comb begin
    w_onehot  = w_gnt_any && ((gnt_i & (gnt_i - ROWS'(1))) == '0);
    w_gnt_bad = !w_onehot || ((gnt_i & ~r_pending) != '0);
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (reset_i)                                     r_err <= 1'b0;
    else if (w_cap_en && (|r_pending) && w_gnt_bad)  r_err <= 1'b1;
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: doc/arb_req_handler.md
# arb_req_handler

Requester-side companion of the row/column priority arbiter in the pixel-array readout path. It latches per-line event pulses into pending flags and presents them as requests to the arbiter. It captures the one-hot grant that comes back, encodes it to a binary address, and emits that address downstream under a valid/ready handshake. On capture it clears the granted line's pending flag, so every event is read out exactly once.

## Interface
- ROWS, default lib_arbiter_pkg::ROWS (8): number of request lines; equals the arbiter width.
- ADDR_W, default $clog2(ROWS) (3): width of the encoded address.

- clk_i  input  1  clock; all logic on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- evt_i  input  ROWS  per-line event pulses; a 1 sets that line's pending flag.
- req_o  output  ROWS  request vector to the arbiter; equals pending_q.
- gnt_i  input  ROWS  one-hot grant from the arbiter; combinational response to req_o in the same cycle.
- addr_o  output  ADDR_W  registered binary index of the granted line.
- valid_o  output  1  addr_o holds an event.
- ready_i  input  1  downstream accepts addr_o.
- busy_o  output  1  high when any flag in pending_q is set, or when valid_o is high.
- err_o  output  1  sticky grant-protocol error (see Configuration).

## Operation
- pending_q[ROWS-1:0] register:
  - next = (pending_q & ~clr) | evt_i.
  - clr is the captured grant on a capture cycle, else 0.
  - Set wins: an event on the line being cleared in the same cycle re-pends it.
  - A repeat event on an already-pending line merges into the existing flag; no count is kept.
- A capture cycle is any cycle with cap_en = (state==IDLE) | (state==SEND & ready_i), and with |gnt_i = 1.
- On capture:
  - addr_o <= enc(gnt_i).
  - valid_o <= 1.
  - The state moves to SEND.
- FSM, two states:
  - IDLE: valid_o = 0. If |gnt_i, capture and go to SEND; else stay in IDLE.
  - SEND: valid_o = 1, and addr_o is stable until handshake. On ready_i:
    - If |gnt_i, capture the next grant and stay in SEND (back-to-back, no bubble).
    - Else clear valid_o and go to IDLE.
- If |pending_q = 1 but gnt_i = 0 while cap_en is high, no capture occurs and the state does not change.
- gnt_i is sampled only when cap_en is high; it is ignored otherwise.
- Encoder: returns the index of the lowest set bit of gnt_i. For a valid one-hot grant this is exact.

## Timing
- Reset values:
  - pending_q = 0, req_o = 0.
  - addr_o = 0, valid_o = 0.
  - state = IDLE.
  - busy_o = 0, err_o = 0.
- Reset mid-operation drops every pending flag and any event in flight. evt_i during the reset cycle is discarded.
- Latency from an evt_i pulse on cycle N to valid_o, when idle and uncontended:
  - Cycle N+1: req_o is asserted.
  - Cycle N+2: valid_o is asserted.
- Throughput: one event per cycle while ready_i is held high and requests remain pending.
- req_o depends only on registered state (pending_q). The only combinational path is gnt_i -> capture logic.
- valid_o never drops without a handshake. addr_o does not change while valid_o=1 & ready_i=0.

## Configuration
- GNT_ONEHOT_CHK_EN defined:
  - During a cycle with cap_en=1 and pending_q≠0, err_o is set if gnt_i is not exactly one-hot (zero or multiple bits), or if gnt_i has any bit outside pending_q.
  - err_o is sticky until reset_i.
  - Capture behaviour is unchanged.
- GNT_ONEHOT_CHK_EN undefined: err_o is tied to 0 and no check logic is built.

## Structure
- lib_arbiter_pkg holds:
  - ROWS.
  - ADDR_W as a localparam.
  - A typedef enum logic {IDLE, SEND} arb_req_state_t.
- Sub-module onehot_to_bin (ROWS -> ADDR_W, purely combinational, lowest-set-bit) implements enc(). Column readout reuses it.
- In the top-level testbench the block is paired with the priority arbiter: req_o -> req_i, gnt_o -> gnt_i.

## Test plan
All scenarios use ROWS=8 and the block paired with the priority arbiter.
- Single event: evt_i=8'h10 for one cycle with ready_i=1 -> req_o=8'h10 at N+1; valid_o=1, addr_o=4 at N+2; pending_q=0 and busy_o=0 at N+3.
- Priority drain: evt_i=8'hA5 in one cycle with ready_i=1 -> addr_o sequence 0,2,5,7 on consecutive cycles; then valid_o=0.
- Backpressure: evt_i=8'h06 with ready_i=0 for 5 cycles -> addr_o=1 held with valid_o=1 throughout, req_o=8'h04. After ready_i rises -> addr_o=2 on the next cycle.
- Set/clear collision: a line is pending and evt_i on that same line arrives in its capture cycle -> the line is read out twice.
- Reset mid-drain: evt_i=8'hFF, then reset_i after two handshakes -> all outputs return to reset values with no further valid_o.
- Check macro: force gnt_i=8'h03 with pending_q=8'h03 -> err_o=1 and stays 1 until reset when GNT_ONEHOT_CHK_EN is defined; err_o=0 when it is undefined.
